// File: rtl/sprite_anim_addr_gen.sv
// sprite_anim_addr_gen: raster position -> 32x32 animated sprite ROM address.
// Player position and facing are latched once per video frame. The walk frame
// advances every TICKS_PER_FRAME frames. Outputs are pipelined so that
// sprite_on/blank_out line up with a ROM that has a 1-cycle registered read.
// Optional build macro: SPRITE_MIRROR_EN. When it is defined, left-facing
// sprites reuse the right-facing banks and are mirrored horizontally.
module sprite_anim_addr_gen #(
    parameter int SPRITE_W        = 32,
    parameter int SCALE_SHIFT     = 0,
    parameter int TICKS_PER_FRAME = 8
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [1:0]  dir,
    input  logic        moving,
    output logic [12:0] rom_address,
    output logic        sprite_on,
    output logic        blank_out,
    output logic        anim_frame
);

    localparam int SPAN = SPRITE_W << SCALE_SHIFT;
    localparam int CW   = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    typedef enum logic {IDLE, WALK} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            anim_n;

    logic [9:0]      drawy_q;
    logic [9:0]      px_l, py_l;
    logic [1:0]      dir_l;
    logic            fs;

    logic [10:0]     x_w, y_w, px_w, py_w, dx, dy;
    logic            hit;
    logic [4:0]      col, row, col_sel;
    logic [1:0]      bank_dir;
    logic [2:0]      bank;
    logic            s1_on, s1_blank;

    // Frame start is the cycle on which DrawY falls from nonzero to 0.
    assign fs = (DrawY == '0) && (drawy_q != '0);

    // Registered copy of DrawY, plus a once-per-frame latch of position and facing.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            drawy_q <= '0;
            px_l    <= '0;
            py_l    <= '0;
            dir_l   <= '0;
        end else begin
            drawy_q <= DrawY;
            if (fs) begin
                px_l  <= pos_x;
                py_l  <= pos_y;
                dir_l <= dir;
            end
        end
    end

    // Hit test and texel coordinates. The 11-bit arithmetic keeps sprites at
    // the right/bottom edges clipped instead of wrapping around.
    always_comb begin
        x_w  = {1'b0, DrawX};
        y_w  = {1'b0, DrawY};
        px_w = {1'b0, px_l};
        py_w = {1'b0, py_l};
        dx   = x_w - px_w;
        dy   = y_w - py_w;
        hit  = (x_w >= px_w) && (x_w < px_w + 11'(SPAN)) &&
               (y_w >= py_w) && (y_w < py_w + 11'(SPAN)) && blank;
        col  = 5'(dx >> SCALE_SHIFT);
        row  = 5'(dy >> SCALE_SHIFT);
`ifdef SPRITE_MIRROR_EN
        if (dir_l == 2'd2) begin
            bank_dir = 2'd3;
            col_sel  = 5'd31 - col;
        end else begin
            bank_dir = dir_l;
            col_sel  = col;
        end
`else
        bank_dir = dir_l;
        col_sel  = col;
`endif
        bank = {bank_dir, anim_frame};
    end

    // Stage 1 registers the ROM address. Stage 2 delays hit and blank so they
    // line up with the ROM read data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            s1_on       <= 1'b0;
            s1_blank    <= 1'b0;
            sprite_on   <= 1'b0;
            blank_out   <= 1'b0;
        end else begin
            rom_address <= hit ? {bank, row, col_sel} : '0;
            s1_on       <= hit;
            s1_blank    <= blank;
            sprite_on   <= s1_on;
            blank_out   <= s1_blank;
        end
    end

    // Walk FSM state register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            anim_frame <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            anim_frame <= anim_n;
        end
    end

    // Walk FSM next-state logic. It only moves on fs, so a single frame never
    // mixes two animation frames. A facing change compares the value being
    // latched now against the one latched at the previous fs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        anim_n  = anim_frame;
        if (fs) begin
            case (state)
                IDLE: begin
                    cnt_n  = '0;
                    anim_n = 1'b0;
                    if (moving) state_n = WALK;
                end
                WALK: begin
                    if (!moving) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        anim_n  = 1'b0;
                    end else if (dir != dir_l) begin
                        cnt_n = '0;
                    end else if (cnt == CW'(TICKS_PER_FRAME - 1)) begin
                        cnt_n  = '0;
                        anim_n = ~anim_frame;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_anim_addr_gen.sv
// Testbench for sprite_anim_addr_gen. Two instances share the same stimulus:
// dut0 (SCALE_SHIFT=0, TICKS_PER_FRAME=8) and dut1 (SCALE_SHIFT=1, TICKS_PER_FRAME=1).
// Frames are shortened: a frame start is produced by driving DrawY 1 then 0.
module tb_sprite_anim_addr_gen;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, moving;
    logic [1:0]  dir;
    logic [12:0] rom_address0, rom_address1;
    logic        sprite_on0, sprite_on1, blank_out0, blank_out1, anim0, anim1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  m;
        logic [12:0] a0, a1;
        logic        on0, on1, bl;
    } exp_t;

    exp_t qa[$];
    exp_t qo[$];
    exp_t ea, eo;
    logic [1:0] chk_m = 2'b00;
    logic [1:0] tag1, tag2;

    sprite_anim_addr_gen #(.SPRITE_W(32), .SCALE_SHIFT(0), .TICKS_PER_FRAME(8)) dut0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
        .rom_address(rom_address0), .sprite_on(sprite_on0), .blank_out(blank_out0),
        .anim_frame(anim0));

    sprite_anim_addr_gen #(.SPRITE_W(32), .SCALE_SHIFT(1), .TICKS_PER_FRAME(1)) dut1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
        .rom_address(rom_address1), .sprite_on(sprite_on1), .blank_out(blank_out1),
        .anim_frame(anim1));

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Delay the check mask to line up with the address (1 cycle) and with sprite_on/blank_out (2 cycles).
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            tag1 <= 2'b00;
            tag2 <= 2'b00;
        end else begin
            tag1 <= chk_m;
            tag2 <= tag1;
        end
    end

    // Monitor: pop expected values and compare them on the falling edge.
    always @(negedge vga_clk) begin
        if (reset_n) begin
            if (tag1 != 2'b00) begin
                if (qa.size() == 0) chk("addr_queue_underflow", 13'd1, 13'd0);
                else begin
                    ea = qa.pop_front();
                    if (ea.m[0]) chk("rom_address0", rom_address0, ea.a0);
                    if (ea.m[1]) chk("rom_address1", rom_address1, ea.a1);
                end
            end
            if (tag2 != 2'b00) begin
                if (qo.size() == 0) chk("on_queue_underflow", 13'd1, 13'd0);
                else begin
                    eo = qo.pop_front();
                    if (eo.m[0]) begin
                        chk("sprite_on0", 13'(sprite_on0), 13'(eo.on0));
                        chk("blank_out0", 13'(blank_out0), 13'(eo.bl));
                    end
                    if (eo.m[1]) begin
                        chk("sprite_on1", 13'(sprite_on1), 13'(eo.on1));
                        chk("blank_out1", 13'(blank_out1), 13'(eo.bl));
                    end
                end
            end
        end
    end

    // Drive one pixel. A nonzero mask m queues the expected results for the selected DUT(s).
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic [1:0] m, input logic [12:0] a0, input logic o0,
                       input logic [12:0] a1, input logic o1);
        exp_t e;
        @(posedge vga_clk); #1;
        DrawX = x; DrawY = y; blank = b; chk_m = m;
        if (m != 2'b00) begin
            e.m = m; e.a0 = a0; e.a1 = a1; e.on0 = o0; e.on1 = o1; e.bl = b;
            qa.push_back(e);
            qo.push_back(e);
        end
    endtask

    // Produce a frame start (DrawY 1 -> 0), then wait one edge so the latch and FSM update.
    task automatic frame_start();
        pix(10'd0, 10'd1, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0);
        pix(10'd0, 10'd0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0);
        @(posedge vga_clk); #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [12:0] left0;
        reset_n = 1'b0;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        pos_x = 10'd100; pos_y = 10'd50; dir = 2'd0; moving = 1'b0;
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("reset_rom_address", rom_address0, 13'h0);
        chk("reset_sprite_on", 13'(sprite_on0), 13'h0);
        chk("reset_blank_out", 13'(blank_out0), 13'h0);
        chk("reset_anim_frame", 13'(anim0), 13'h0);
        reset_n = 1'b1;

        // Before the first fs the latched position is (0,0).
        pix(10'd100, 10'd50, 1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        pix(10'd5,   10'd5,  1'b0, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);

        // Sprite at (100,50), facing down, idle.
        frame_start();
        pix(10'd100, 10'd50, 1'b1, 2'b11, 13'h000, 1'b1, 13'h000, 1'b1);
        pix(10'd131, 10'd81, 1'b1, 2'b11, 13'h3FF, 1'b1, 13'h1EF, 1'b1);
        pix(10'd132, 10'd81, 1'b1, 2'b11, 13'h000, 1'b0, 13'h1F0, 1'b1);
        pix(10'd99,  10'd50, 1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        pix(10'd100, 10'd82, 1'b1, 2'b11, 13'h000, 1'b0, 13'h200, 1'b1);
        pix(10'd110, 10'd60, 1'b0, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        pix(10'd163, 10'd50, 1'b1, 2'b11, 13'h000, 1'b0, 13'h01F, 1'b1);
        pix(10'd164, 10'd50, 1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);

        // A position change mid-frame is ignored until the next fs.
        pos_x = 10'd0; pos_y = 10'd0;
        pix(10'd100, 10'd50, 1'b1, 2'b11, 13'h000, 1'b1, 13'h000, 1'b1);
        pix(10'd5,   10'd5,  1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        frame_start();
        pix(10'd0,  10'd0, 1'b1, 2'b11, 13'h000, 1'b1, 13'h000, 1'b1);
        pix(10'd1,  10'd0, 1'b1, 2'b11, 13'h001, 1'b1, 13'h000, 1'b1);
        pix(10'd63, 10'd0, 1'b1, 2'b11, 13'h000, 1'b0, 13'h01F, 1'b1);
        pix(10'd64, 10'd0, 1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        pix(10'd2,  10'd3, 1'b1, 2'b11, 13'h062, 1'b1, 13'h021, 1'b1);

        // Right-edge clipping at pos_x=620.
        pos_x = 10'd620;
        frame_start();
        pix(10'd619, 10'd0, 1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        pix(10'd620, 10'd0, 1'b1, 2'b11, 13'h000, 1'b1, 13'h000, 1'b1);
        pix(10'd639, 10'd0, 1'b1, 2'b11, 13'h013, 1'b1, 13'h009, 1'b1);
        pix(10'd640, 10'd0, 1'b0, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);
        pix(10'd0,   10'd1, 1'b1, 2'b11, 13'h000, 1'b0, 13'h000, 1'b0);

        // Walking to the right: dut0 steps every 8 fs, dut1 every fs.
        pos_x = 10'd100; pos_y = 10'd50; dir = 2'd3; moving = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            frame_start();
            chk($sformatf("anim0_fs%0d", k), 13'(anim0), (k == 9) ? 13'd1 : 13'd0);
            chk($sformatf("anim1_fs%0d", k), 13'(anim1), 13'((k - 1) % 2));
            if (k == 8) pix(10'd100, 10'd50, 1'b1, 2'b01, 13'h1800, 1'b1, '0, 1'b0);
            if (k == 9) pix(10'd101, 10'd51, 1'b1, 2'b01, 13'h1C21, 1'b1, '0, 1'b0);
        end

        // A facing change while walking holds the current walk frame.
        dir = 2'd2;
        frame_start();
        chk("anim0_dirchg", 13'(anim0), 13'd1);
        chk("anim1_dirchg", 13'(anim1), 13'd0);
`ifdef SPRITE_MIRROR_EN
        pix(10'd100, 10'd50, 1'b1, 2'b01, 13'h1C1F, 1'b1, '0, 1'b0);
`else
        pix(10'd100, 10'd50, 1'b1, 2'b01, 13'h1400, 1'b1, '0, 1'b0);
`endif

        // Stopping returns to walk frame 0 (bank 6 when facing right).
        dir = 2'd3; moving = 1'b0;
        frame_start();
        chk("anim0_stop", 13'(anim0), 13'd0);
        chk("anim1_stop", 13'(anim1), 13'd0);
        pix(10'd100, 10'd50, 1'b1, 2'b01, 13'h1800, 1'b1, '0, 1'b0);

        // Facing left while idle: bank 4, or bank 6 mirrored when mirroring is enabled.
        dir = 2'd2;
        frame_start();
`ifdef SPRITE_MIRROR_EN
        left0 = 13'h181F;
`else
        left0 = 13'h1000;
`endif
        pix(10'd100, 10'd50, 1'b1, 2'b11, left0, 1'b1, left0, 1'b1);

        // Asynchronous reset mid-line: outputs clear before the next clock edge.
        repeat (3) pix(10'd100, 10'd50, 1'b1, 2'b00, '0, 1'b0, '0, 1'b0);
        @(negedge vga_clk); #2;
        chk("pre_reset_sprite_on", 13'(sprite_on0), 13'd1);
        chk("pre_reset_rom_address", rom_address0, left0);
        reset_n = 1'b0;
        #1;
        chk("async_rom_address", rom_address0, 13'h0);
        chk("async_sprite_on", 13'(sprite_on0), 13'h0);
        chk("async_blank_out", 13'(blank_out0), 13'h0);
        chk("async_sprite_on1", 13'(sprite_on1), 13'h0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("addr_queue_drained", 13'(qa.size()), 13'd0);
        chk("on_queue_drained", 13'(qo.size()), 13'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
